// File: rtl/rom_pkg.sv
// Shared definitions for the ROM scan controller.
// State encoding and ROM depth live here so the top and bench agree.
package rom_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_SEND  = 2'd2;
  localparam state_t S_FIN   = 2'd3;

  localparam int ROM_DEPTH = 12;
  localparam int SUM_W     = 16;

endpackage

// File: rtl/rom_scan_ctrl_scan_stats.sv
// Running max/min/sum accumulator over accepted ROM entries.
// clr restarts the statistics; en folds din into them.
module scan_stats
  import rom_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    max_o,
  output logic [DW-1:0]    min_o,
  output logic [SUM_W-1:0] sum_o
);

  logic [DW-1:0]    max_q, max_d;
  logic [DW-1:0]    min_q, min_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    sum_d = sum_q;
    if (clr) begin
      max_d = '0;
      min_d = '1;
      sum_d = '0;
    end else if (en) begin
      if (din > max_q) max_d = din;
      if (din < min_q) min_d = din;
      // Sum wraps modulo 2^SUM_W by construction.
      sum_d = sum_q + SUM_W'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '1;
      sum_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
      sum_q <= sum_d;
    end
  end

  assign max_o = max_q;
  assign min_o = min_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/rom_scan_ctrl.sv
// Sequential scanner over an external ROM with a valid/ready output
// and running statistics on every accepted entry.
module rom_scan_ctrl
  import rom_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = ROM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    len,
  output logic [AW-1:0]    Dir,
  input  logic [DW-1:0]    Dato_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_dato,
  output logic [AW-1:0]    out_idx,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    max_o,
  output logic [DW-1:0]    min_o,
  output logic [SUM_W-1:0] sum_o
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] dir_q, dir_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] n_q, n_d;
  logic [DW-1:0] dato_q, dato_d;
  logic          clr;
  logic          hs;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    n_d     = n_q;
    dato_d  = dato_q;
    clr     = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            n_d     = (len > DEPTH_A) ? DEPTH_A : len;
            dir_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        dato_d  = Dato_e;
        idx_d   = dir_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          hs = 1'b1;
          if (idx_q == n_q - AW'(1)) begin
            state_d = S_FIN;
          end else begin
            dir_d   = dir_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      dato_q  <= dato_d;
    end
  end

  assign Dir       = dir_q;
  assign out_dato  = dato_q;
  assign out_idx   = idx_q;
  assign out_valid = (state_q == S_SEND);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  scan_stats #(
    .DW (DW)
  ) u_stats (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (hs),
    .din   (dato_q),
    .max_o (max_o),
    .min_o (min_o),
    .sum_o (sum_o)
  );

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl against a 12-entry ROM model.
module tb_rom_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  dir;
  logic [7:0]  dato_e;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_dato;
  logic [7:0]  out_idx;
  logic        busy;
  logic        done;
  logic [7:0]  max_o;
  logic [7:0]  min_o;
  logic [15:0] sum_o;

  logic [7:0] rom [0:11];
  int vecs;
  int errs;
  int done_cnt;

  rom_scan_ctrl #(
    .AW    (8),
    .DW    (8),
    .DEPTH (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .Dir       (dir),
    .Dato_e    (dato_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dato  (out_dato),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .max_o     (max_o),
    .min_o     (min_o),
    .sum_o     (sum_o)
  );

  assign dato_e = (dir < 8'd12) ? rom[dir[3:0]] : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int mx, input int mn,
                           input int sm);
    chk({tag, " max"}, 32'(max_o), 32'(mx));
    chk({tag, " min"}, 32'(min_o), 32'(mn));
    chk({tag, " sum"}, 32'(sum_o), 32'(sm));
  endtask

  // Full scan with out_ready held high; n is the expected entry count.
  task automatic run_scan(input string tag, input logic [7:0] l,
                          input int n);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s fetch%0d valid", tag, i), 32'(out_valid), 0);
      @(negedge clk);
      chk($sformatf("%s send%0d valid", tag, i), 32'(out_valid), 1);
      chk($sformatf("%s send%0d idx", tag, i), 32'(out_idx), 32'(i));
      chk($sformatf("%s send%0d dato", tag, i), 32'(out_dato),
          32'(rom[i]));
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " fin valid"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, " done low"}, 32'(done), 0);
    chk({tag, " idle"}, 32'(busy), 0);
  endtask

  initial begin
    rom = '{8'd90, 8'd80, 8'd40, 8'd60, 8'd50, 8'd40,
            8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102};
    vecs      = 0;
    errs      = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(out_valid), 0);
    chk("rst done", 32'(done), 0);
    chk("rst dir", 32'(dir), 0);
    chk("rst dato", 32'(out_dato), 0);
    chk("rst idx", 32'(out_idx), 0);
    chk_stats("rst", 0, 255, 0);
    rst = 1'b0;
    @(negedge clk);

    run_scan("full", 8'd12, 12);
    chk_stats("full", 102, 10, 723);

    // Backpressure on the second entry.
    start = 1'b1;
    len   = 8'd3;
    @(negedge clk);
    start = 1'b0;
    chk("bp fetch0 valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("bp send0 valid", 32'(out_valid), 1);
    chk("bp send0 dato", 32'(out_dato), 90);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp send1 valid", 32'(out_valid), 1);
    chk("bp send1 dato", 32'(out_dato), 80);
    @(negedge clk);
    chk("bp hold valid", 32'(out_valid), 1);
    chk("bp hold dato", 32'(out_dato), 80);
    chk("bp hold idx", 32'(out_idx), 1);
    chk("bp hold sum", 32'(sum_o), 90);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp fetch2 valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("bp send2 dato", 32'(out_dato), 40);
    chk("bp send2 idx", 32'(out_idx), 2);
    @(negedge clk);
    chk("bp done", 32'(done), 1);
    @(negedge clk);
    chk("bp idle", 32'(busy), 0);
    chk_stats("bp", 90, 40, 210);

    // Over-long request clamps to the ROM depth.
    done_cnt = 0;
    run_scan("clamp", 8'd20, 12);
    chk("clamp last idx", 32'(out_idx), 11);
    chk("clamp dir", 32'(dir), 11);
    repeat (3) @(negedge clk);
    chk("clamp done count", 32'(done_cnt), 1);
    chk("clamp stays idle", 32'(busy), 0);

    // Zero-length request goes straight to FIN.
    start = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero done", 32'(done), 1);
    chk("zero valid", 32'(out_valid), 0);
    chk_stats("zero", 0, 255, 0);
    @(negedge clk);
    chk("zero done low", 32'(done), 0);
    chk("zero idle", 32'(busy), 0);
    chk("zero valid2", 32'(out_valid), 0);

    // Mid-scan start is ignored, reset during SEND of entry 5.
    start = 1'b1;
    len   = 8'd12;
    @(negedge clk);
    for (int i = 0; i <= 5; i++) begin
      start = (i == 2);
      len   = (i == 2) ? 8'd3 : 8'd12;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("ab send%0d idx", i), 32'(out_idx), 32'(i));
      chk($sformatf("ab send%0d dato", i), 32'(out_dato), 32'(rom[i]));
      if (i < 5) @(negedge clk);
    end
    chk("ab pre sum", 32'(sum_o), 320);
    rst = 1'b1;
    @(negedge clk);
    chk("ab busy", 32'(busy), 0);
    chk("ab valid", 32'(out_valid), 0);
    chk("ab done", 32'(done), 0);
    chk("ab dir", 32'(dir), 0);
    chk("ab idx", 32'(out_idx), 0);
    chk_stats("ab", 0, 255, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ab post busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
